counter_read_latch: RTL
=======================

Name: counter_read_latch

Overview:
- Read-side companion to the 8254 control-word decoder: one instance per counter.
- Consumes that counter's latch flags and control-word-change strobe.
- Holds the count output latch (OL) and the status latch, and sequences byte reads onto the data bus per the programmed RW mode.
- Sits between the counter element and the read mux that drives DataBus.

Parameters:
- CNT_W, 16, width of counter element value (fixed 16 for 8254 compatibility)

Ports:
- CLK  input  1  system clock, all state updates on rising edge
- RST_N  input  1  asynchronous active-low reset
- RD  input  1  one-cycle read strobe, already qualified by chip/counter select
- CounterLatch  input  1  count latch command for this counter (one-cycle pulse)
- StatusLatch  input  1  status latch command for this counter (one-cycle pulse)
- ChgControlWord  input  1  new control word written for this counter (one-cycle pulse)
- ControlWord  input  6  {RW[1:0], M[2:0], BCD}; sampled when ChgControlWord=1
- CountValue  input  CNT_W  live counter element value
- OutPin  input  1  current OUT level of this counter
- NullCount  input  1  null-count flag from the counter
- DataOut  output  8  registered read byte
- DataValid  output  1  one-cycle pulse, DataOut valid

Behaviour:
- Reset (async, RST_N=0):
  - RwMode=2'b11, ModeBcd=4'b0000, BytePtr=LSB.
  - OL=0, CountLatched=0, StatusByte=0, StatusLatched=0.
  - DataOut=8'h00, DataValid=0.
- Control word (ChgControlWord=1):
  - Store ControlWord[5:4] as RwMode and [3:0] as ModeBcd.
  - Clear CountLatched and StatusLatched; BytePtr=LSB.
  - Highest priority: an RD or latch command in the same cycle is ignored (DataValid stays 0).
- Count latch (CounterLatch=1, no Chg):
  - If CountLatched=0 at cycle start: OL<=CountValue, CountLatched<=1.
  - Otherwise ignored; the first latched value persists.
- Status latch (StatusLatch=1, no Chg):
  - If StatusLatched=0: StatusByte<={OutPin, NullCount, RwMode, ModeBcd}, StatusLatched<=1.
  - Otherwise ignored.
- Both latch commands in one cycle (read-back): each is applied independently per the rules above.
- Read (RD=1, no Chg). The byte is chosen in priority order; DataOut is registered and DataValid=1 on the next cycle (latency 1):
  1. StatusLatched=1: byte=StatusByte; clear StatusLatched; BytePtr unchanged.
  2. Else source S = OL if CountLatched else CountValue. Byte select by RwMode:
     - 01: S[7:0]
     - 10: S[15:8]
     - 11: BytePtr=LSB gives S[7:0] then BytePtr<=MSB; BytePtr=MSB gives S[15:8] then BytePtr<=LSB.
  3. CountLatched clears after the final byte of the sequence: after one read in modes 01/10, after the MSB read in mode 11.
- RwMode=00 is never stored; the decoder does not pulse Chg for latch commands. If seen, treat as a read returning 8'h00 with no state change.
- Same-cycle RD with a latch command:
  - The read uses pre-cycle state.
  - The latch command is judged against pre-cycle flags. A latch held before this cycle stays ignored even if this read releases it.
  - If the flag was clear, the latch captures this cycle's CountValue/status; the read returns live data for that byte.
- Back-to-back RD every cycle is legal; each produces its own DataValid.
- DataOut holds its last value when DataValid=0.
- Mid-sequence reset: all state returns to reset values immediately, including BytePtr.

Test Plan:
- Reset, then Chg with ControlWord=6'b110100 (RW=11, mode 2, binary); CountValue=16'h1234; RD x2 -> DataOut 8'h34 then 8'h12, DataValid one cycle after each RD.
- RW=11: CounterLatch with CountValue=16'hABCD; change CountValue to 16'h0001; second CounterLatch at 16'h0002; RD x2 -> 8'hCD, 8'hAB. Next RD -> live 8'h02.
- Read-back: CounterLatch+StatusLatch same cycle with OutPin=1, NullCount=0, RW=11, mode 3, BCD=0 -> RD x3 returns 8'b10110110, then OL LSB, then OL MSB.
- RW=01: CounterLatch at 16'h5A3C; RD -> 8'h3C and latch released; second RD -> live LSB.
- RW=11: one RD (LSB), then Chg with RW=10 -> BytePtr reset; CountValue=16'h7F00, RD -> 8'h7F. RD and Chg in the same cycle -> no DataValid.
- Assert RST_N=0 mid-sequence with OL held -> DataOut=8'h00 and DataValid=0 immediately. After release, RD returns live LSB.

Source files
------------

// File: rtl/counter_read_latch_if.sv
// Read-side bus of one 8254 counter.
// master: control-word decoder, counter element and read qualifier (drive the inputs).
// slave : counter_read_latch (returns DataOut / DataValid).
//   RD             one-cycle read strobe, already chip/counter qualified
//   CounterLatch   count latch command pulse
//   StatusLatch    status latch command pulse
//   ChgControlWord new control word pulse, ControlWord = {RW[1:0], M[2:0], BCD}
//   CountValue     live counter element value
//   OutPin         current OUT level
//   NullCount      null-count flag
//   DataOut        registered read byte
//   DataValid      one-cycle pulse qualifying DataOut
interface counter_read_latch_if #(
  parameter int unsigned CNT_W = 16
);
  logic             RD;
  logic             CounterLatch;
  logic             StatusLatch;
  logic             ChgControlWord;
  logic [5:0]       ControlWord;
  logic [CNT_W-1:0] CountValue;
  logic             OutPin;
  logic             NullCount;
  logic [7:0]       DataOut;
  logic             DataValid;

  modport master (
    output RD, CounterLatch, StatusLatch, ChgControlWord, ControlWord,
    output CountValue, OutPin, NullCount,
    input  DataOut, DataValid
  );

  modport slave (
    input  RD, CounterLatch, StatusLatch, ChgControlWord, ControlWord,
    input  CountValue, OutPin, NullCount,
    output DataOut, DataValid
  );
endinterface

// File: rtl/counter_read_latch.sv
// Per-counter read path of an 8254: holds the count output latch and the status latch and
// sequences byte reads onto the data bus according to the programmed RW mode.
// Ports:
//   CLK    system clock, rising edge
//   RST_N  asynchronous active-low reset
//   bus    counter_read_latch_if.slave (commands, live count/status in; read byte out)
module counter_read_latch #(
  parameter int unsigned CNT_W = 16
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  counter_read_latch_if.slave   bus
);

  typedef enum logic [0:0] {PtrLsb, PtrMsb} byte_ptr_e;

  logic [1:0]       rw_mode_q, rw_mode_d;
  logic [3:0]       mode_bcd_q, mode_bcd_d;
  byte_ptr_e        byte_ptr_q, byte_ptr_d;
  logic [CNT_W-1:0] ol_q, ol_d;
  logic             count_latched_q, count_latched_d;
  logic [7:0]       status_byte_q, status_byte_d;
  logic             status_latched_q, status_latched_d;
  logic [7:0]       data_out_q, data_out_d;
  logic             data_valid_q, data_valid_d;
  logic [CNT_W-1:0] src;

  always_comb begin
    rw_mode_d        = rw_mode_q;
    mode_bcd_d       = mode_bcd_q;
    byte_ptr_d       = byte_ptr_q;
    ol_d             = ol_q;
    count_latched_d  = count_latched_q;
    status_byte_d    = status_byte_q;
    status_latched_d = status_latched_q;
    data_out_d       = data_out_q;
    data_valid_d     = 1'b0;
    src              = count_latched_q ? ol_q : bus.CountValue;

    if (bus.ChgControlWord) begin
      // Reprogramming wins over any read or latch arriving in the same cycle.
      rw_mode_d        = bus.ControlWord[5:4];
      mode_bcd_d       = bus.ControlWord[3:0];
      count_latched_d  = 1'b0;
      status_latched_d = 1'b0;
      byte_ptr_d       = PtrLsb;
    end else begin
      // Read is evaluated first on pre-cycle state; latch commands below then judge
      // against the pre-cycle flags, so a latch held coming in is never re-armed here.
      if (bus.RD) begin
        data_valid_d = 1'b1;
        if (rw_mode_q == 2'b00) begin
          data_out_d = 8'h00;
        end else if (status_latched_q) begin
          data_out_d       = status_byte_q;
          status_latched_d = 1'b0;
        end else begin
          case (rw_mode_q)
            2'b01: begin
              data_out_d      = src[7:0];
              count_latched_d = 1'b0;
            end
            2'b10: begin
              data_out_d      = src[CNT_W-1 -: 8];
              count_latched_d = 1'b0;
            end
            default: begin
              if (byte_ptr_q == PtrMsb) begin
                data_out_d      = src[CNT_W-1 -: 8];
                byte_ptr_d      = PtrLsb;
                count_latched_d = 1'b0;
              end else begin
                data_out_d = src[7:0];
                byte_ptr_d = PtrMsb;
              end
            end
          endcase
        end
      end

      if (bus.CounterLatch && !count_latched_q) begin
        ol_d            = bus.CountValue;
        count_latched_d = 1'b1;
      end

      if (bus.StatusLatch && !status_latched_q) begin
        status_byte_d    = {bus.OutPin, bus.NullCount, rw_mode_q, mode_bcd_q};
        status_latched_d = 1'b1;
      end
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      rw_mode_q        <= 2'b11;
      mode_bcd_q       <= 4'b0000;
      byte_ptr_q       <= PtrLsb;
      ol_q             <= '0;
      count_latched_q  <= 1'b0;
      status_byte_q    <= 8'h00;
      status_latched_q <= 1'b0;
      data_out_q       <= 8'h00;
      data_valid_q     <= 1'b0;
    end else begin
      rw_mode_q        <= rw_mode_d;
      mode_bcd_q       <= mode_bcd_d;
      byte_ptr_q       <= byte_ptr_d;
      ol_q             <= ol_d;
      count_latched_q  <= count_latched_d;
      status_byte_q    <= status_byte_d;
      status_latched_q <= status_latched_d;
      data_out_q       <= data_out_d;
      data_valid_q     <= data_valid_d;
    end
  end

  assign bus.DataOut   = data_out_q;
  assign bus.DataValid = data_valid_q;

endmodule
